// File: rtl/bw_const_ext_stage.sv
// Decode-front stage: folds CON1..CON3 postfix words into the immediate of the preceding
// base instruction and emits one record per base.
module bw_const_ext_stage #(
  parameter int unsigned IW       = 40,
  parameter int unsigned IMM_W    = 80,
  parameter int unsigned CON_BITS = 27,
  parameter int unsigned MAX_CON  = 3,
  parameter int unsigned OFS_W    = $clog2(IMM_W + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             kill_i,
  input  logic             drain_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [IW-1:0]    in_ir_i,
  input  logic [IMM_W-1:0] in_imm_i,
  input  logic [OFS_W-1:0] in_immw_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [IW-1:0]    out_ir_o,
  output logic [IMM_W-1:0] out_imm_o,
  output logic [1:0]       out_ncon_o,
  output logic             out_err_o,
  output logic             orphan_o
);

  localparam logic [6:0] OpCon1 = 7'h7D;
  localparam logic [6:0] OpCon2 = 7'h7E;
  localparam logic [6:0] OpCon3 = 7'h7F;

  typedef enum logic [1:0] {StEmpty, StCollect, StEmit} state_e;

  state_e             state_q, state_d;
  logic [IW-1:0]      ir_q, ir_d;
  logic [IMM_W-1:0]   imm_q, imm_d;
  logic [OFS_W-1:0]   ofs_q, ofs_d;
  logic [1:0]         cnt_q, cnt_d;
  logic               err_q, err_d;
  logic               pend_v_q, pend_v_d;
  logic [IW-1:0]      pend_ir_q, pend_ir_d;
  logic [IMM_W-1:0]   pend_imm_q, pend_imm_d;
  logic [OFS_W-1:0]   pend_immw_q, pend_immw_d;
  logic               out_valid_q, out_valid_d;
  logic [IW-1:0]      out_ir_q, out_ir_d;
  logic [IMM_W-1:0]   out_imm_q, out_imm_d;
  logic [1:0]         out_ncon_q, out_ncon_d;
  logic               out_err_q, out_err_d;
  logic               orphan_q, orphan_d;

  logic                accept;
  logic                in_is_con;
  logic [1:0]          in_ord;
  logic [CON_BITS-1:0] payload;
  logic [IMM_W-1:0]    pay_ext;
  logic [IMM_W-1:0]    low_mask;
  logic [IMM_W-1:0]    merged;
  logic [OFS_W-1:0]    ofs_next;
  logic [1:0]          cnt_inc;
  logic                bad_ord;
  logic                last_con;
  logic                go_emit;

  assign in_ready_o = (state_q != StEmit) && !kill_i;
  assign accept     = in_valid_i && in_ready_o;

  always_comb begin
    in_is_con = 1'b1;
    in_ord    = 2'd0;
    case (in_ir_i[6:0])
      OpCon1:  in_ord = 2'd1;
      OpCon2:  in_ord = 2'd2;
      OpCon3:  in_ord = 2'd3;
      default: in_is_con = 1'b0;
    endcase
  end

  // Chunk lands at ofs; everything above it takes the payload sign. A shift past IMM_W
  // yields a zero one-hot, so the mask becomes all ones and the merge is a no-op.
  assign payload  = in_ir_i[IW-1 -: CON_BITS];
  assign pay_ext  = {{(IMM_W - CON_BITS){payload[CON_BITS-1]}}, payload};
  assign low_mask = ({{(IMM_W - 1){1'b0}}, 1'b1} << ofs_q) - 1'b1;
  assign merged   = (ofs_q >= OFS_W'(IMM_W)) ? imm_q
                                             : ((imm_q & low_mask) | (pay_ext << ofs_q));
  assign ofs_next = (ofs_q >= OFS_W'(IMM_W - CON_BITS)) ? OFS_W'(IMM_W)
                                                        : ofs_q + OFS_W'(CON_BITS);
  assign cnt_inc  = cnt_q + 2'd1;
  assign bad_ord  = in_ord != cnt_inc;
  assign last_con = cnt_inc == 2'(MAX_CON);

  always_comb begin
    state_d     = state_q;
    ir_d        = ir_q;
    imm_d       = imm_q;
    ofs_d       = ofs_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    pend_v_d    = pend_v_q;
    pend_ir_d   = pend_ir_q;
    pend_imm_d  = pend_imm_q;
    pend_immw_d = pend_immw_q;
    out_valid_d = out_valid_q;
    out_ir_d    = out_ir_q;
    out_imm_d   = out_imm_q;
    out_ncon_d  = out_ncon_q;
    out_err_d   = out_err_q;
    orphan_d    = 1'b0;
    go_emit     = 1'b0;

    unique case (state_q)
      StEmpty: begin
        if (accept) begin
          if (in_is_con) begin
            orphan_d = 1'b1;
          end else begin
            ir_d    = in_ir_i;
            imm_d   = in_imm_i;
            ofs_d   = in_immw_i;
            cnt_d   = 2'd0;
            err_d   = 1'b0;
            state_d = StCollect;
          end
        end
      end
      StCollect: begin
        if (accept && in_is_con) begin
          imm_d   = merged;
          ofs_d   = ofs_next;
          cnt_d   = cnt_inc;
          err_d   = err_q | bad_ord;
          go_emit = bad_ord | last_con | drain_i;
        end else if (accept) begin
          // Next base waits in the pend slot while this record is emitted.
          pend_v_d    = 1'b1;
          pend_ir_d   = in_ir_i;
          pend_imm_d  = in_imm_i;
          pend_immw_d = in_immw_i;
          go_emit     = 1'b1;
        end else if (drain_i) begin
          go_emit = 1'b1;
        end
      end
      StEmit: begin
        if (out_ready_i) begin
          out_valid_d = 1'b0;
          if (pend_v_q) begin
            ir_d     = pend_ir_q;
            imm_d    = pend_imm_q;
            ofs_d    = pend_immw_q;
            cnt_d    = 2'd0;
            err_d    = 1'b0;
            pend_v_d = 1'b0;
            state_d  = StCollect;
          end else begin
            state_d = StEmpty;
          end
        end
      end
      default: state_d = StEmpty;
    endcase

    if (go_emit) begin
      state_d     = StEmit;
      out_valid_d = 1'b1;
      out_ir_d    = ir_d;
      out_imm_d   = imm_d;
      out_ncon_d  = cnt_d;
      out_err_d   = err_d;
    end

    if (kill_i) begin
      state_d     = StEmpty;
      pend_v_d    = 1'b0;
      cnt_d       = 2'd0;
      out_valid_d = 1'b0;
      orphan_d    = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StEmpty;
      ir_q        <= '0;
      imm_q       <= '0;
      ofs_q       <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      pend_v_q    <= 1'b0;
      pend_ir_q   <= '0;
      pend_imm_q  <= '0;
      pend_immw_q <= '0;
      out_valid_q <= 1'b0;
      out_ir_q    <= '0;
      out_imm_q   <= '0;
      out_ncon_q  <= '0;
      out_err_q   <= 1'b0;
      orphan_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      ir_q        <= ir_d;
      imm_q       <= imm_d;
      ofs_q       <= ofs_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      pend_v_q    <= pend_v_d;
      pend_ir_q   <= pend_ir_d;
      pend_imm_q  <= pend_imm_d;
      pend_immw_q <= pend_immw_d;
      out_valid_q <= out_valid_d;
      out_ir_q    <= out_ir_d;
      out_imm_q   <= out_imm_d;
      out_ncon_q  <= out_ncon_d;
      out_err_q   <= out_err_d;
      orphan_q    <= orphan_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_ir_o    = out_ir_q;
  assign out_imm_o   = out_imm_q;
  assign out_ncon_o  = out_ncon_q;
  assign out_err_o   = out_err_q;
  assign orphan_o    = orphan_q;

endmodule

// File: tb/tb_bw_const_ext_stage.sv
// Scoreboard bench for bw_const_ext_stage: directed scenarios plus random word streams
// checked against a bit-level immediate-assembly model.
module tb_bw_const_ext_stage;
  localparam int IW = 40;
  localparam int IMM_W = 80;
  localparam int CB = 27;

  typedef struct {
    logic [IW-1:0]    ir;
    logic [IMM_W-1:0] imm;
    logic [1:0]       ncon;
    logic             err;
  } rec_t;

  logic             clk = 1'b0;
  logic             rst, kill, drain, in_valid, in_ready;
  logic             out_valid, out_err, orphan;
  logic             out_ready = 1'b1;
  logic [IW-1:0]    in_ir, out_ir;
  logic [IMM_W-1:0] in_imm, out_imm;
  logic [6:0]       in_immw;
  logic [1:0]       out_ncon;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic rnd_ready = 1'b0;
  logic ready_force = 1'b1;

  rec_t exp_q[$];
  logic             m_active = 1'b0;
  logic [IW-1:0]    m_ir;
  logic [IMM_W-1:0] m_imm;
  int               m_immw;
  int               m_n;
  logic [CB-1:0]    m_pay[3];
  int               exp_orphans = 0;
  int               orphan_seen = 0;

  bw_const_ext_stage dut (
    .clk_i(clk), .rst_i(rst), .kill_i(kill), .drain_i(drain),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_ir_i(in_ir), .in_imm_i(in_imm),
    .in_immw_i(in_immw), .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_ir_o(out_ir), .out_imm_o(out_imm), .out_ncon_o(out_ncon), .out_err_o(out_err),
    .orphan_o(orphan)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    #1;
    out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : ready_force;
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [IMM_W-1:0] sext_w(input logic [IMM_W-1:0] raw, input int w);
    logic [IMM_W-1:0] r = raw;
    for (int b = w; b < IMM_W; b++) r[b] = raw[w-1];
    return r;
  endfunction

  // Bit b comes from the base below immw, else from chunk (b-immw)/CB, else from the
  // sign of the last chunk.
  function automatic logic [IMM_W-1:0] assemble();
    logic [IMM_W-1:0] r;
    for (int b = 0; b < IMM_W; b++) begin
      if (m_n == 0 || b < m_immw) r[b] = m_imm[b];
      else begin
        int j = (b - m_immw) / CB;
        if (j < m_n) r[b] = m_pay[j][(b - m_immw) - CB * j];
        else r[b] = m_pay[m_n-1][CB-1];
      end
    end
    return r;
  endfunction

  function automatic logic [6:0] con_op(input int ord);
    return (ord == 1) ? 7'h7D : (ord == 2) ? 7'h7E : 7'h7F;
  endfunction

  task automatic model_word(input logic [IW-1:0] ir, input logic [IMM_W-1:0] imm, input int w);
    int ord = (ir[6:0] == 7'h7D) ? 1 : (ir[6:0] == 7'h7E) ? 2 : (ir[6:0] == 7'h7F) ? 3 : 0;
    if (!m_active) begin
      if (ord != 0) exp_orphans++;
      else begin m_active = 1; m_ir = ir; m_imm = imm; m_immw = w; m_n = 0; end
    end else if (ord != 0) begin
      logic bad = (ord != m_n + 1);
      m_pay[m_n] = ir[IW-1 -: CB];
      m_n++;
      if (bad || m_n == 3) begin
        exp_q.push_back('{m_ir, assemble(), 2'(m_n), bad});
        m_active = 0;
      end
    end else begin
      exp_q.push_back('{m_ir, assemble(), 2'(m_n), 1'b0});
      m_ir = ir; m_imm = imm; m_immw = w; m_n = 0;
    end
  endtask

  task automatic model_flush();
    exp_q.delete();
    m_active = 0;
  endtask

  // Called aligned to posedge+1; returns aligned to posedge+1 after the accepting edge.
  task automatic send_word(input logic [IW-1:0] ir, input logic [IMM_W-1:0] imm,
                           input int w, output int t);
    bit ok = 0;
    in_valid = 1; in_ir = ir; in_imm = imm; in_immw = 7'(w);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
    end
    t = cyc;
    if (!ok) begin checks++; errors++; $display("FAIL accept_timeout: got 0 expected 1"); end
    else model_word(ir, imm, w);
    @(posedge clk); #1;
    in_valid = 0;
  endtask

  task automatic send_base(input logic [IMM_W-1:0] imm, input int w, output int t);
    send_word({33'($urandom), 7'($urandom_range(0, 124))}, imm, w, t);
  endtask

  task automatic send_con(input int ord, input logic [CB-1:0] p, output int t);
    send_word({p, 6'($urandom), con_op(ord)}, 80'($urandom), $urandom_range(0, 80), t);
  endtask

  task automatic do_drain();
    bit ok = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
    end
    if (!ok) begin checks++; errors++; $display("FAIL drain_timeout: got 0 expected 1"); end
    drain = 1;
    if (m_active) begin
      exp_q.push_back('{m_ir, assemble(), 2'(m_n), 1'b0});
      m_active = 0;
    end
    @(posedge clk); #1;
    drain = 0;
  endtask

  task automatic wait_valid(output int c);
    bit ok = 0;
    c = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (out_valid) begin ok = 1; c = cyc; break; end
    end
    if (!ok) begin checks++; errors++; $display("FAIL valid_timeout: got 0 expected 1"); end
  endtask

  task automatic sync();
    @(posedge clk); #1;
  endtask

  task automatic monitor();
    logic pv = 0, pr = 0, pk = 0, prst = 1;
    logic [122:0] pdata = '0;
    forever begin
      @(negedge clk);
      if (orphan) orphan_seen++;
      if (pv && !pr && !pk && !prst) begin
        chk("hold_valid", out_valid, 1'b1);
        chk("hold_data", {out_ir, out_imm, out_ncon, out_err}, pdata);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_record: got ir %0h imm %0h expected none", out_ir, out_imm);
        end else begin
          rec_t e = exp_q.pop_front();
          chk("rec_ir", out_ir, e.ir);
          chk("rec_imm", out_imm, e.imm);
          chk("rec_ncon", out_ncon, e.ncon);
          chk("rec_err", out_err, e.err);
        end
      end
      pv = out_valid; pr = out_ready; pk = kill; prst = rst;
      pdata = {out_ir, out_imm, out_ncon, out_err};
    end
  endtask

  initial begin
    int t, c, vcnt;
    logic [122:0] snap;
    rst = 1; kill = 0; drain = 0; in_valid = 0; in_ir = '0; in_imm = '0; in_immw = '0;
    fork monitor(); join_none
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    chk("reset_valid", out_valid, 1'b0);
    chk("reset_ready", in_ready, 1'b1);
    chk("reset_orphan", orphan, 1'b0);
    chk("reset_data", {out_ir, out_imm, out_ncon, out_err}, 123'd0);

    // Orphan CON straight after reset
    sync();
    send_con(1, 27'h5, t);
    @(negedge clk);
    chk("orphan_pulse", orphan, 1'b1);
    chk("orphan_no_valid", out_valid, 1'b0);
    @(negedge clk);
    chk("orphan_one_cycle", orphan, 1'b0);

    // RI base + CON1, terminated by a second base that waits for drain
    sync();
    send_base({IMM_W{1'b1}}, 15, t);
    send_con(1, 27'h1, c);
    send_base(80'hA, 5, c);
    wait_valid(c);
    chk("t1_latency", c - t, 3);
    chk("t1_imm", out_imm, 80'h0000_0000_0000_0000_FFFF);
    chk("t1_ncon", out_ncon, 2'd1);
    chk("t1_err", out_err, 1'b0);
    sync();
    vcnt = 0;
    repeat (6) begin @(negedge clk); if (out_valid) vcnt++; end
    chk("t1_no_emit_before_drain", vcnt, 0);
    sync();
    do_drain();
    wait_valid(c);
    chk("t1_drain_imm", out_imm, 80'hA);
    chk("t1_drain_ncon", out_ncon, 2'd0);

    // Full three-CON chain
    sync();
    send_base({IMM_W{1'b1}}, 6, t);
    send_con(1, 27'h7FFFFFF, c);
    send_con(2, 27'h0, c);
    send_con(3, 27'h1, c);
    wait_valid(c);
    chk("t2_latency", c - t, 4);
    chk("t2_imm", out_imm, 80'h0000_1000_0001_FFFF_FFFF);
    chk("t2_ncon", out_ncon, 2'd3);

    // Base then base: first record at t+2
    sync();
    send_base(80'h3, 4, t);
    send_base(80'h1, 3, c);
    wait_valid(c);
    chk("t2b_latency", c - t, 2);
    sync();
    do_drain();
    wait_valid(c);

    // Out-of-sequence ordinal, then an orphan
    sync();
    send_base(80'h7, 4, t);
    send_con(2, 27'h123, c);
    wait_valid(c);
    chk("t3_err", out_err, 1'b1);
    chk("t3_ncon", out_ncon, 2'd1);
    sync();
    send_con(3, 27'h55, c);
    @(negedge clk);
    chk("t3_orphan", orphan, 1'b1);

    // Backpressure in EMIT with a pending base
    @(negedge clk);
    ready_force = 0;
    sync();
    send_base(sext_w(80'h1234, 16), 16, t);
    send_con(1, 27'($urandom), c);
    send_base(80'h2, 3, c);
    wait_valid(c);
    snap = {out_ir, out_imm, out_ncon, out_err};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t5_stable", {out_ir, out_imm, out_ncon, out_err}, snap);
      chk("t5_in_ready", in_ready, 1'b0);
    end
    ready_force = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (!out_valid) break;
    end
    chk("t5_released", out_valid, 1'b0);
    chk("t5_pend_collect", in_ready, 1'b1);
    sync();
    do_drain();
    wait_valid(c);

    // Kill in EMIT with a pending base
    @(negedge clk);
    ready_force = 0;
    sync();
    send_base(80'h9, 5, t);
    send_base(80'h4, 4, c);
    wait_valid(c);
    sync();
    kill = 1;
    #1;
    chk("t6_kill_blocks_ready", in_ready, 1'b0);
    @(posedge clk); #1;
    kill = 0;
    model_flush();
    @(negedge clk);
    chk("t6_kill_valid", out_valid, 1'b0);
    chk("t6_kill_empty", in_ready, 1'b1);
    ready_force = 1;
    sync();
    do_drain();
    repeat (8) @(negedge clk);

    // Reset mid-COLLECT
    sync();
    send_base(80'h6, 4, t);
    send_con(1, 27'h42, c);
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    model_flush();
    @(negedge clk);
    chk("t7_rst_valid", out_valid, 1'b0);
    chk("t7_rst_data", {out_ir, out_imm, out_ncon, out_err}, 123'd0);
    sync();
    do_drain();
    repeat (6) @(negedge clk);

    // Random streams with random backpressure
    rnd_ready = 1;
    sync();
    for (int i = 0; i < 400; i++) begin
      int r = $urandom_range(0, 9);
      if (r < 5) begin
        int ord = (m_active && $urandom_range(0, 3) != 0) ? m_n + 1 : $urandom_range(1, 3);
        send_con(ord, 27'($urandom), t);
      end else if (r < 8) begin
        int w = $urandom_range(1, 40);
        logic [IMM_W-1:0] raw = {16'($urandom), $urandom, $urandom};
        send_base(sext_w(raw, w), w, t);
      end else begin
        do_drain();
      end
    end
    do_drain();
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) break;
    end
    repeat (3) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    chk("orphan_count", orphan_seen, exp_orphans);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/bw_const_ext_stage.md
Name: bw_const_ext_stage

Overview:
- Registered decode-front stage that folds constant-extension postfix words (CON1..CON3) into the immediate of the preceding base instruction.
- Sits between fetch-align and the combinational decoder. Consumes one 40-bit instruction word per handshake.
- Emits one record per base instruction: the base instruction, its fully assembled immediate, the CON count, and an error flag.
- Generalises immediate width, chunk width and postfix depth. Adds ordinal checking, orphan detection, drain and kill.

Parameters:
IW, 40, instruction width
IMM_W, 80, assembled immediate width
CON_BITS, 27, payload bits per CON word, taken from ir[IW-1 -: CON_BITS]
MAX_CON, 3, maximum CON words per base instruction (1..3)
OFS_W, $clog2(IMM_W+1), width of the chunk-offset register

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
kill_i  in  1  discard all held state (pipeline flush)
drain_i  in  1  force emit of a base currently collecting
in_valid_i  in  1  input word valid
in_ready_o  out  1  stage accepts input word
in_ir_i  in  IW  instruction word; opcode in ir[6:0], CON1/CON2/CON3 per rfBlackWidowPkg
in_imm_i  in  IMM_W  base immediate, already sign-extended by pre-decode
in_immw_i  in  OFS_W  significant width of the base immediate (e.g. 15 for RI, 6 for CMPI)
out_valid_o  out  1  record valid
out_ready_i  in  1  consumer accepts record
out_ir_o  out  IW  base instruction
out_imm_o  out  IMM_W  assembled immediate
out_ncon_o  out  2  number of CON words merged
out_err_o  out  1  CON ordinal out of sequence
orphan_o  out  1  one-cycle pulse: CON word received with no base held

Behaviour:
- States: EMPTY, COLLECT, EMIT. Side registers: pend_v/pend_ir/pend_imm/pend_immw (one-entry next-base slot), cnt, ofs.
- Reset (rst_i, sampled on clk_i): state EMPTY, pend_v=0, cnt=0. All outputs 0: out_valid_o=0, out_ir_o/out_imm_o/out_ncon_o/out_err_o=0, orphan_o=0. in_ready_o=1.
- in_ready_o = 1 in EMPTY and COLLECT; 0 in EMIT.
- EMPTY:
  - Accept non-CON: latch ir and imm, ofs=in_immw_i, cnt=0, err=0, go to COLLECT.
  - Accept CON: word dropped, orphan_o=1 next cycle, stay EMPTY.
- COLLECT, accept CON with ordinal k:
  - Merge: imm[ofs +: CON_BITS] = payload, truncated at IMM_W-1. Bits above the chunk are sign-extended from the payload MSB. ofs += CON_BITS, saturating at IMM_W; once ofs==IMM_W, further payloads are counted but not merged. cnt += 1.
  - If k != cnt+1 (pre-increment value): set err.
  - If new cnt == MAX_CON, or err set: go to EMIT.
- COLLECT, accept non-CON: load it into the pend slot and go to EMIT. The base record is complete.
- COLLECT with drain_i=1 and no accept that cycle: go to EMIT. drain_i is ignored in EMPTY and EMIT.
- EMIT:
  - out_valid_o=1; outputs are held stable until out_ready_i.
  - On handshake: if pend_v, load pend into the working regs, clear pend_v, go to COLLECT; else go to EMPTY.
- Output registers are updated only on entry to EMIT. out_valid_o falls the cycle after the handshake unless EMIT is re-entered.
- kill_i: highest priority below rst_i. Next state EMPTY, pend_v=0, out_valid_o=0. An input word offered that cycle is not accepted (in_ready_o forced 0).
- Latency:
  - Base accepted at cycle t followed by MAX_CON back-to-back CONs: out_valid_o at t+MAX_CON+1.
  - Base followed by a non-CON at t+1: out_valid_o at t+2.
- Throughput: at most one record per 2 cycles, because EMIT is a no-accept bubble.
- Simultaneous drain_i and an accepted CON: the CON is merged first, then EMIT.

Test Plan:
- Reset, then base RI (in_imm_i = sext(15'h7FFF), in_immw_i=15), then CON1 payload 27'h1, then non-CON → record out_imm_o=80'h0000_0000_0000_0000_FFFF, ncon=1, err=0. The second base is emitted only after drain_i.
- Base immw=6 imm=6'h3F, then CON1 27'h7FFFFFF, CON2 27'h0, CON3 27'h1 → ncon=3, emitted without drain, out_imm_o bits[5:0]=3F, [32:6]=7FFFFFF, [59:33]=0, [79:60]=1. out_valid_o at t+4.
- Base then CON2 (skipping CON1) → out_err_o=1, ncon=1, EMIT immediately; the next CON word in EMPTY gives orphan_o pulse.
- CON1 with no base after reset → orphan_o=1 for exactly one cycle, out_valid_o stays 0.
- Hold out_ready_i=0 for 5 cycles in EMIT with a pending base → outputs stable, in_ready_o=0. Release → record taken, pending base enters COLLECT next cycle.
- kill_i asserted in EMIT with pend_v=1 → next cycle out_valid_o=0, EMPTY, no records from pend ever emitted. rst_i mid-COLLECT behaves identically.
